// File: rtl/axi_burst_undec_slv.sv
// AXI4 subordinate that terminates undecided bursts (burst = 2'b11) into NumSlots
// burst-sized buffers. Each burst is TotalBurstLength bits. Write and read FSMs run independently.
package axi_burst_undec_pkg;
    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 128;
    localparam int unsigned StrbW = DataW / 8;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } aw_chan_t;

    typedef aw_chan_t ar_chan_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [StrbW-1:0] strb;
        logic             last;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
        logic           user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic             user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;
endpackage

module axi_burst_undec_slv #(
    parameter int unsigned TotalBurstLength = 512,
    parameter int unsigned DataWidth        = 128,
    parameter int unsigned NumSlots         = 4,
    parameter type aw_chan_t  = axi_burst_undec_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_burst_undec_pkg::w_chan_t,
    parameter type b_chan_t   = axi_burst_undec_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_burst_undec_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_burst_undec_pkg::r_chan_t,
    parameter type axi_req_t  = axi_burst_undec_pkg::axi_req_t,
    parameter type axi_resp_t = axi_burst_undec_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    localparam int unsigned Beats  = TotalBurstLength / DataWidth;
    localparam int unsigned OffW   = $clog2(TotalBurstLength / 8);
    localparam int unsigned SlotW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned CntW   = $clog2(Beats) + 1;
    localparam int unsigned MemD   = NumSlots * Beats;
    localparam int unsigned MemAW  = (MemD > 1) ? $clog2(MemD) : 1;
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] CntLast = CntW'(Beats - 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    if (TotalBurstLength % DataWidth != 0) begin : g_chk_len
        $error("TotalBurstLength must be a multiple of DataWidth");
    end
    if (Beats < 1) begin : g_chk_beats
        $error("Beats must be at least 1");
    end
    if ((NumSlots & (NumSlots - 1)) != 0 || NumSlots < 1) begin : g_chk_slots
        $error("NumSlots must be a power of two");
    end

    logic [1:0]           w_state_q, w_state_d;
    logic [$bits(slv_req_i.aw.id)-1:0] w_id_q, w_id_d, r_id_q, r_id_d;
    logic [SlotW-1:0]     w_slot_q, w_slot_d, r_slot_q, r_slot_d;
    logic [CntW-1:0]      w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
    logic                 w_bad_q, w_bad_d, w_err_q, w_err_d;
    logic [0:0]           r_state_q, r_state_d;
    logic                 r_bad_q, r_bad_d;
    logic                 mem_we;
    logic [MemAW-1:0]     w_idx, r_idx;
    logic [DataWidth-1:0] mem_q [MemD];
    logic                 unused_req;

    // Only the slot bits and a few control fields matter; the rest of the request is ignored.
    assign unused_req = ^slv_req_i;

    assign w_idx = MemAW'(w_slot_q) * MemAW'(Beats) + MemAW'(w_cnt_q);
    assign r_idx = MemAW'(r_slot_q) * MemAW'(Beats) + MemAW'(r_cnt_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_slot_d  = w_slot_q;
        w_bad_d   = w_bad_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (slv_req_i.aw_valid) begin
                w_id_d    = slv_req_i.aw.id;
                w_slot_d  = (NumSlots > 1) ? slv_req_i.aw.addr[OffW +: SlotW] : '0;
                w_bad_d   = (slv_req_i.aw.burst != 2'b11);
                w_cnt_d   = '0;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (slv_req_i.w_valid) begin
                // Beats beyond the buffer are swallowed until last; the counter saturates.
                mem_we = (w_cnt_q < CntW'(Beats)) && !w_bad_q;
                if (w_cnt_q != CntMax) w_cnt_d = w_cnt_q + 1'b1;
                if (slv_req_i.w.last) begin
                    w_err_d   = w_bad_q || (w_cnt_q != CntLast);
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (slv_req_i.b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_slot_d  = r_slot_q;
        r_bad_d   = r_bad_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: if (slv_req_i.ar_valid) begin
                r_id_d    = slv_req_i.ar.id;
                r_slot_d  = (NumSlots > 1) ? slv_req_i.ar.addr[OffW +: SlotW] : '0;
                r_bad_d   = (slv_req_i.ar.burst != 2'b11);
                r_cnt_d   = '0;
                r_state_d = R_DATA;
            end
            R_DATA: if (slv_req_i.r_ready) begin
                if (r_cnt_q == CntLast) r_state_d = R_IDLE;
                else                    r_cnt_d   = r_cnt_q + 1'b1;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_slot_q  <= '0;
            w_bad_q   <= 1'b0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_slot_q  <= '0;
            r_bad_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_slot_q  <= w_slot_d;
            w_bad_q   <= w_bad_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_slot_q  <= r_slot_d;
            r_bad_q   <= r_bad_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else if (mem_we) begin
            for (int b = 0; b < DataWidth / 8; b++) begin
                if (slv_req_i.w.strb[b]) mem_q[w_idx][b*8 +: 8] <= slv_req_i.w.data[b*8 +: 8];
            end
        end
    end

    // Outputs are forced low while reset is asserted, not just after the first edge.
    always_comb begin
        slv_resp_o = '0;
        if (!rst_i) begin
            slv_resp_o.aw_ready = (w_state_q == W_IDLE);
            slv_resp_o.w_ready  = (w_state_q == W_DATA);
            slv_resp_o.b_valid  = (w_state_q == W_RESP);
            slv_resp_o.b.id     = w_id_q;
            slv_resp_o.b.resp   = w_err_q ? RespSlverr : RespOkay;
            slv_resp_o.ar_ready = (r_state_q == R_IDLE);
            slv_resp_o.r_valid  = (r_state_q == R_DATA);
            slv_resp_o.r.id     = r_id_q;
            slv_resp_o.r.data   = r_bad_q ? '0 : mem_q[r_idx];
            slv_resp_o.r.resp   = r_bad_q ? RespSlverr : RespOkay;
            slv_resp_o.r.last   = (r_cnt_q == CntLast);
        end
    end
endmodule

// File: tb/tb_axi_burst_undec_slv.sv
// Directed bench for axi_burst_undec_slv: write/read bursts, error bursts, R stalls
// and reset in the middle of a write.
module tb_axi_burst_undec_slv;
    import axi_burst_undec_pkg::*;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    axi_req_t  req;
    axi_resp_t resp;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    axi_burst_undec_slv dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst);
        int t;
        @(negedge clk);
        req.aw.id = id; req.aw.addr = addr; req.aw.burst = burst;
        req.aw.len = 8'd3; req.aw.size = 3'd4; req.aw_valid = 1'b1;
        t = 0;
        while (!resp.aw_ready && t < 50) begin @(negedge clk); t++; end
        check("aw_ready_wait", resp.aw_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req.aw_valid = 1'b0;
        check("w_ready_after_aw", resp.w_ready, 1);
    endtask

    task automatic do_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int t;
        @(negedge clk);
        req.w.data = data; req.w.strb = strb; req.w.last = last; req.w_valid = 1'b1;
        t = 0;
        while (!resp.w_ready && t < 50) begin @(negedge clk); t++; end
        check("w_ready_wait", resp.w_ready, 1);
        @(posedge clk);
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] bresp);
        @(negedge clk);
        req.w_valid = 1'b0; req.w.last = 1'b0;
        check("b_valid_latency", resp.b_valid, 1);
        check("b_id", resp.b.id, id);
        check("b_resp", resp.b.resp, bresp);
        req.b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.b_ready = 1'b0;
        check("b_valid_clear", resp.b_valid, 0);
        check("aw_ready_back", resp.aw_ready, 1);
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst);
        int t;
        @(negedge clk);
        req.ar.id = id; req.ar.addr = addr; req.ar.burst = burst;
        req.ar.len = 8'd0; req.ar.size = 3'd4; req.ar_valid = 1'b1;
        t = 0;
        while (!resp.ar_ready && t < 50) begin @(negedge clk); t++; end
        check("ar_ready_wait", resp.ar_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req.ar_valid = 1'b0;
        check("r_valid_latency", resp.r_valid, 1);
    endtask

    // Consumes exp_q in order; every presented beat (stalled or not) must match the head.
    task automatic read_burst(input logic [3:0] id, input logic [1:0] rresp, input bit rnd);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            req.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("r_valid_hold", resp.r_valid, 1);
            if (resp.r_valid) begin
                check("r_data", resp.r.data, exp_q[0]);
                check("r_last", resp.r.last, exp_q.size() == 1);
                check("r_resp", resp.r.resp, rresp);
                check("r_id", resp.r.id, id);
                if (req.r_ready) void'(exp_q.pop_front());
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        req.r_ready = 1'b0;
        check("r_beats_left", exp_q.size(), 0);
        check("r_valid_idle", resp.r_valid, 0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs_zero(input string tag);
        check({tag, "_aw_ready"}, resp.aw_ready, 0);
        check({tag, "_w_ready"}, resp.w_ready, 0);
        check({tag, "_ar_ready"}, resp.ar_ready, 0);
        check({tag, "_b_valid"}, resp.b_valid, 0);
        check({tag, "_r_valid"}, resp.r_valid, 0);
    endtask

    logic [127:0] d5 [4];
    logic [1:0]   p;

    initial begin
        req = '0;

        // Reset release
        repeat (3) @(negedge clk);
        check_idle_outputs_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rel_aw_ready", resp.aw_ready, 1);
        check("rel_ar_ready", resp.ar_ready, 1);
        check("rel_w_ready", resp.w_ready, 0);

        // Full undecided burst to slot 1, then read it back
        do_aw(4'd3, 32'h40, 2'b11);
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            do_w({64{p}}, 16'hFFFF, i == 3);
        end
        do_b(4'd3, OKAY);
        do_ar(4'd5, 32'h40, 2'b11);
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            exp_q.push_back({64{p}});
        end
        read_burst(4'd5, OKAY, 1'b0);

        // Early last on beat 1 into slot 0
        do_aw(4'd1, 32'h00, 2'b11);
        do_w({16{8'h10}}, 16'hFFFF, 1'b0);
        do_w({16{8'h11}}, 16'hFFFF, 1'b1);
        do_b(4'd1, SLVERR);
        do_ar(4'd1, 32'h00, 2'b11);
        exp_q.push_back({16{8'h10}});
        exp_q.push_back({16{8'h11}});
        exp_q.push_back('0);
        exp_q.push_back('0);
        read_burst(4'd1, OKAY, 1'b0);

        // INCR write is discarded; INCR read returns zeros with SLVERR
        do_aw(4'd2, 32'hC0, 2'b01);
        for (int i = 0; i < 4; i++) do_w('1, 16'hFFFF, i == 3);
        do_b(4'd2, SLVERR);
        do_ar(4'd2, 32'hC0, 2'b01);
        repeat (4) exp_q.push_back('0);
        read_burst(4'd2, SLVERR, 1'b0);
        do_ar(4'd6, 32'hC0, 2'b11);
        repeat (4) exp_q.push_back('0);
        read_burst(4'd6, OKAY, 1'b0);

        // Slot 2 with a partial strobe on beat 1, read with random r_ready stalls
        for (int i = 0; i < 4; i++) d5[i] = {4{32'hA5A5_0000 | 32'(i)}};
        do_aw(4'd4, 32'h80, 2'b11);
        for (int i = 0; i < 4; i++) do_w(d5[i], (i == 1) ? 16'h00FF : 16'hFFFF, i == 3);
        do_b(4'd4, OKAY);
        do_ar(4'd7, 32'h8C, 2'b11);
        exp_q.push_back(d5[0]);
        exp_q.push_back({64'h0, d5[1][63:0]});
        exp_q.push_back(d5[2]);
        exp_q.push_back(d5[3]);
        read_burst(4'd7, OKAY, 1'b1);

        // Reset during write beat 2
        do_aw(4'd9, 32'h80, 2'b11);
        do_w({16{8'hEE}}, 16'hFFFF, 1'b0);
        do_w({16{8'hEF}}, 16'hFFFF, 1'b0);
        @(negedge clk);
        req.w.data = {16{8'hF0}}; req.w_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_idle_outputs_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        req.w_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_b_valid", resp.b_valid, 0);
            check("post_rst_aw_ready", resp.aw_ready, 1);
            check("post_rst_w_ready", resp.w_ready, 0);
        end
        for (int s = 0; s < 4; s++) begin
            do_ar(4'(s), 32'(s * 64), 2'b11);
            repeat (4) exp_q.push_back('0);
            read_burst(4'(s), OKAY, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
